// File: rtl/memory_access_stage.sv
// ----------------------------------------------------------------------------
// memory_access_stage
//
// MEM stage of the pipeline. It sits right after the execute stage and has
// four jobs:
//   - resolve branches combinationally,
//   - issue word loads/stores on a ready-handshake data-memory port, waiting
//     a bounded number of cycles for the memory to answer,
//   - hold the upstream pipeline while an access is outstanding,
//   - own the MEM/WB pipeline register that feeds write-back.
//
// An access that is misaligned, or that times out, is dropped. It still
// reaches write-back, but as a faulted entry with its writes suppressed.
//
// Ports
//   clk_i, reset_i                clock, async active-high reset
//   *_MEMORYACCESS                EX/MEM register outputs (control + data)
//   dmem_ready_i, dmem_rdata_i    memory completion handshake / load data
//   dmem_req_o, dmem_we_o         request valid / store select
//   dmem_addr_o, dmem_wdata_o     word address / store data
//   PCSrc_o, PCTarget_o           branch decision and target
//   stall_o                       hold upstream stages and EX/MEM register
//   *_WRITEBACK                   MEM/WB pipeline register outputs
// ----------------------------------------------------------------------------
module memory_access_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        MemtoReg_MEMORYACCESS,
    input  logic        MemWrite_MEMORYACCESS,
    input  logic        MemRead_MEMORYACCESS,
    input  logic        RegWrite_MEMORYACCESS,
    input  logic        Branch_MEMORYACCESS,
    input  logic        zero_MEMORYACCESS,
    input  logic [31:0] PCTarget_MEMORYACCESS,
    input  logic [31:0] ALUResult_MEMORYACCESS,
    input  logic [31:0] ReadData2_MEMORYACCESS,
    input  logic [4:0]  Write_Register_MEMORYACCESS,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic        PCSrc_o,
    output logic [31:0] PCTarget_o,
    output logic        stall_o,
    output logic [31:0] ReadData_WRITEBACK,
    output logic [31:0] ALUResult_WRITEBACK,
    output logic [4:0]  Write_Register_WRITEBACK,
    output logic        MemtoReg_WRITEBACK,
    output logic        RegWrite_WRITEBACK,
    output logic        fault_WRITEBACK
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // What the MEM/WB register loads this cycle.
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_FAULT   = 2'd1,
        ACT_BUBBLE  = 2'd2
    } act_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;

    logic            w_mem_op;
    logic            w_aligned;
    logic            w_is_load;
    logic            w_stall;
    act_t            w_act;
    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [31:0]     w_rdata_cap;

    assign w_mem_op  = MemRead_MEMORYACCESS | MemWrite_MEMORYACCESS;
    assign w_aligned = (ALUResult_MEMORYACCESS[1:0] == 2'b00);
    // A store wins when both read and write are set, so that is not a load.
    assign w_is_load = MemRead_MEMORYACCESS & ~MemWrite_MEMORYACCESS;

    // Branch resolution is independent of memory stalls.
    assign PCSrc_o    = Branch_MEMORYACCESS & zero_MEMORYACCESS;
    assign PCTarget_o = PCTarget_MEMORYACCESS;

    // Upstream holds during a stall, so the address and data can be driven
    // straight from the EX/MEM inputs and stay stable while we wait.
    assign dmem_req_o   = (r_state == S_WAIT) | (w_mem_op & w_aligned);
    assign dmem_we_o    = MemWrite_MEMORYACCESS;
    assign dmem_addr_o  = ALUResult_MEMORYACCESS;
    assign dmem_wdata_o = ReadData2_MEMORYACCESS;
    assign stall_o      = w_stall;

    // Only a completing load carries memory data into write-back.
    assign w_rdata_cap = w_is_load ? dmem_rdata_i : 32'h0000_0000;

    // Next-state, stall and MEM/WB-action decode.
    always_comb begin
        w_stall     = 1'b0;
        w_act       = ACT_CAPTURE;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!w_mem_op) begin
                    w_act = ACT_CAPTURE;
                end else if (!w_aligned) begin
                    w_act = ACT_FAULT;
                end else if (dmem_ready_i) begin
                    w_act = ACT_CAPTURE;
                end else begin
                    w_stall     = 1'b1;
                    w_act       = ACT_BUBBLE;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_WAIT: begin
                // A ready in the timeout cycle still completes the access.
                if (dmem_ready_i) begin
                    w_act       = ACT_CAPTURE;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_act       = ACT_FAULT;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_act     = ACT_BUBBLE;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_act       = ACT_CAPTURE;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and MEM/WB pipeline register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state                  <= S_IDLE;
            r_cnt                    <= CNT_ZERO;
            ReadData_WRITEBACK       <= 32'h0000_0000;
            ALUResult_WRITEBACK      <= 32'h0000_0000;
            Write_Register_WRITEBACK <= 5'd0;
            MemtoReg_WRITEBACK       <= 1'b0;
            RegWrite_WRITEBACK       <= 1'b0;
            fault_WRITEBACK          <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Every entry keeps the address and destination, which helps debug.
            ALUResult_WRITEBACK      <= ALUResult_MEMORYACCESS;
            Write_Register_WRITEBACK <= Write_Register_MEMORYACCESS;
            case (w_act)
                ACT_CAPTURE: begin
                    ReadData_WRITEBACK <= w_rdata_cap;
                    MemtoReg_WRITEBACK <= MemtoReg_MEMORYACCESS;
                    RegWrite_WRITEBACK <= RegWrite_MEMORYACCESS;
                    fault_WRITEBACK    <= 1'b0;
                end
                ACT_FAULT: begin
                    ReadData_WRITEBACK <= 32'h0000_0000;
                    MemtoReg_WRITEBACK <= 1'b0;
                    RegWrite_WRITEBACK <= 1'b0;
                    fault_WRITEBACK    <= 1'b1;
                end
                ACT_BUBBLE: begin
                    ReadData_WRITEBACK <= 32'h0000_0000;
                    MemtoReg_WRITEBACK <= 1'b0;
                    RegWrite_WRITEBACK <= 1'b0;
                    fault_WRITEBACK    <= 1'b0;
                end
                default: begin
                    ReadData_WRITEBACK <= 32'h0000_0000;
                    MemtoReg_WRITEBACK <= 1'b0;
                    RegWrite_WRITEBACK <= 1'b0;
                    fault_WRITEBACK    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// ----------------------------------------------------------------------------
// tb_memory_access_stage
//
// The stimulus process plays both the EX/MEM register and the data memory.
// For each instruction it decides, up front, how many cycles the memory will
// take to answer. From that it pushes the complete sequence of expected
// MEM/WB entries into a queue: bubbles first, then the final entry.
//
// A separate monitor process pops one entry after every clock edge and
// compares it with the MEM/WB outputs. The combinational outputs (stall,
// request, memory port, branch) are checked inline, once per cycle.
// ----------------------------------------------------------------------------
module tb_memory_access_stage;

    localparam int MAX_WAIT = 15;
    localparam int NEVER    = 1000;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        MemtoReg_MEMORYACCESS, MemWrite_MEMORYACCESS, MemRead_MEMORYACCESS;
    logic        RegWrite_MEMORYACCESS, Branch_MEMORYACCESS, zero_MEMORYACCESS;
    logic [31:0] PCTarget_MEMORYACCESS, ALUResult_MEMORYACCESS, ReadData2_MEMORYACCESS;
    logic [4:0]  Write_Register_MEMORYACCESS;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic        dmem_req_o, dmem_we_o, PCSrc_o, stall_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, PCTarget_o;
    logic [31:0] ReadData_WRITEBACK, ALUResult_WRITEBACK;
    logic [4:0]  Write_Register_WRITEBACK;
    logic        MemtoReg_WRITEBACK, RegWrite_WRITEBACK, fault_WRITEBACK;

    memory_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i                       (clk_i),
        .reset_i                     (reset_i),
        .MemtoReg_MEMORYACCESS       (MemtoReg_MEMORYACCESS),
        .MemWrite_MEMORYACCESS       (MemWrite_MEMORYACCESS),
        .MemRead_MEMORYACCESS        (MemRead_MEMORYACCESS),
        .RegWrite_MEMORYACCESS       (RegWrite_MEMORYACCESS),
        .Branch_MEMORYACCESS         (Branch_MEMORYACCESS),
        .zero_MEMORYACCESS           (zero_MEMORYACCESS),
        .PCTarget_MEMORYACCESS       (PCTarget_MEMORYACCESS),
        .ALUResult_MEMORYACCESS      (ALUResult_MEMORYACCESS),
        .ReadData2_MEMORYACCESS      (ReadData2_MEMORYACCESS),
        .Write_Register_MEMORYACCESS (Write_Register_MEMORYACCESS),
        .dmem_ready_i                (dmem_ready_i),
        .dmem_rdata_i                (dmem_rdata_i),
        .dmem_req_o                  (dmem_req_o),
        .dmem_we_o                   (dmem_we_o),
        .dmem_addr_o                 (dmem_addr_o),
        .dmem_wdata_o                (dmem_wdata_o),
        .PCSrc_o                     (PCSrc_o),
        .PCTarget_o                  (PCTarget_o),
        .stall_o                     (stall_o),
        .ReadData_WRITEBACK          (ReadData_WRITEBACK),
        .ALUResult_WRITEBACK         (ALUResult_WRITEBACK),
        .Write_Register_WRITEBACK    (Write_Register_WRITEBACK),
        .MemtoReg_WRITEBACK          (MemtoReg_WRITEBACK),
        .RegWrite_WRITEBACK          (RegWrite_WRITEBACK),
        .fault_WRITEBACK             (fault_WRITEBACK)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        m2r;
        logic        rw;
        logic        fault;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    bit  mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic zero_inputs();
        MemtoReg_MEMORYACCESS = 1'b0; MemWrite_MEMORYACCESS = 1'b0;
        MemRead_MEMORYACCESS  = 1'b0; RegWrite_MEMORYACCESS = 1'b0;
        Branch_MEMORYACCESS   = 1'b0; zero_MEMORYACCESS     = 1'b0;
        PCTarget_MEMORYACCESS = 32'h0; ALUResult_MEMORYACCESS = 32'h0;
        ReadData2_MEMORYACCESS = 32'h0; Write_Register_MEMORYACCESS = 5'd0;
        dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    // Present one instruction. k = cycle (0 = first) on which memory answers.
    task automatic issue(input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic br, input logic z, input logic [31:0] pct,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input int k);
        bit          is_req, load, done_ok;
        int          n;
        wb_t         e;
        logic [31:0] mem_val;
        is_req  = (mr | mw) && (alu[1:0] == 2'b00);
        load    = mr & ~mw;
        mem_val = $urandom;
        done_ok = !is_req || (k <= MAX_WAIT);
        n       = !is_req ? 0 : ((k <= MAX_WAIT) ? k : MAX_WAIT);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                e = '0; e.alu = alu; e.rd = rd;
                for (int b = 0; b < n; b++) exp_q.push_back(e);
                if (!(mr | mw)) begin
                    e.m2r = m2r; e.rw = rw; e.chk_rdata = 1'b1; e.rdata = 32'h0;
                end else if (!is_req || !done_ok) begin
                    e.fault = 1'b1;
                end else begin
                    e.m2r = m2r; e.rw = rw; e.chk_rdata = load; e.rdata = load ? mem_val : 32'h0;
                end
                exp_q.push_back(e);
                mon_en = 1'b1;
            end
            MemRead_MEMORYACCESS = mr; MemWrite_MEMORYACCESS = mw;
            MemtoReg_MEMORYACCESS = m2r; RegWrite_MEMORYACCESS = rw;
            Branch_MEMORYACCESS = br; zero_MEMORYACCESS = z;
            PCTarget_MEMORYACCESS = pct; ALUResult_MEMORYACCESS = alu;
            ReadData2_MEMORYACCESS = wd; Write_Register_MEMORYACCESS = rd;
            dmem_ready_i = is_req ? (c == k) : 1'($urandom);
            dmem_rdata_i = (is_req && c == k) ? mem_val : $urandom;
            #1;
            chk("stall", 64'(stall_o), 64'(is_req && (c != k) && (c < MAX_WAIT)));
            chk("req", 64'(dmem_req_o), 64'(is_req));
            if (is_req)
                chk("memport", {dmem_we_o, dmem_addr_o, dmem_wdata_o}, {mw, alu, wd});
            chk("branch", {PCSrc_o, PCTarget_o}, {br & z, pct});
        end
    endtask

    // Scoreboard monitor: one MEM/WB entry per clock edge.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL wb_underflow no expected entry at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (ALUResult_WRITEBACK !== e.alu || Write_Register_WRITEBACK !== e.rd ||
                        MemtoReg_WRITEBACK !== e.m2r || RegWrite_WRITEBACK !== e.rw ||
                        fault_WRITEBACK !== e.fault ||
                        (e.chk_rdata && ReadData_WRITEBACK !== e.rdata)) begin
                        n_err++;
                        $display("FAIL wb_entry got alu=%h rd=%0d rdata=%h m2r=%b rw=%b f=%b expected alu=%h rd=%0d rdata=%h(chk %b) m2r=%b rw=%b f=%b",
                                 ALUResult_WRITEBACK, Write_Register_WRITEBACK, ReadData_WRITEBACK,
                                 MemtoReg_WRITEBACK, RegWrite_WRITEBACK, fault_WRITEBACK,
                                 e.alu, e.rd, e.rdata, e.chk_rdata, e.m2r, e.rw, e.fault);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int          sel;
        int          k;
        logic        mr, mw;
        logic [31:0] a;
        reset_i = 1'b1;
        zero_inputs();
        #1;
        chk("reset_wb", {ReadData_WRITEBACK, ALUResult_WRITEBACK, Write_Register_WRITEBACK,
                         MemtoReg_WRITEBACK, RegWrite_WRITEBACK, fault_WRITEBACK}, 64'h0);
        chk("reset_req_stall", {dmem_req_o, stall_o}, 64'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Directed cases
        issue(0, 0, 0, 1, 0, 0, 32'h0, 32'h55, 32'h0, 5'd3, 0);                       // ALU op
        issue(1, 0, 1, 1, 0, 0, 32'h0, 32'h100, 32'h0, 5'd4, 0);                      // zero-wait load
        issue(0, 1, 0, 0, 0, 0, 32'h0, 32'h104, 32'h1234_5678, 5'd0, 3);              // store, 3 waits
        issue(1, 0, 1, 1, 0, 0, 32'h0, 32'h102, 32'h0, 5'd5, 0);                      // misaligned
        issue(1, 0, 1, 1, 0, 0, 32'h0, 32'h200, 32'h0, 5'd6, NEVER);                  // timeout
        issue(1, 0, 1, 1, 0, 0, 32'h0, 32'h204, 32'h0, 5'd7, MAX_WAIT);               // ready on last cycle
        issue(0, 0, 0, 0, 1, 1, 32'h40, 32'h8, 32'h0, 5'd0, 0);                       // taken branch
        issue(1, 1, 0, 0, 0, 0, 32'h0, 32'h300, 32'hCAFE_F00D, 5'd8, 1);              // read+write = store

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            sel = $urandom % 8;
            mr  = (sel >= 2 && sel <= 4) || sel == 7;
            mw  = (sel >= 5);
            a   = $urandom;
            if ($urandom % 5 != 0) a[1:0] = 2'b00;
            sel = $urandom % 10;
            if (sel < 6)      k = $urandom % 4;
            else if (sel < 8) k = 13 + ($urandom % 4);
            else              k = NEVER;
            issue(mr, mw, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, a, $urandom, 5'($urandom), k);
        end
        @(posedge clk_i);
        #2;
        mon_en = 1'b0;
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        // Reset in the middle of a wait aborts the access immediately.
        @(negedge clk_i);
        MemRead_MEMORYACCESS = 1'b1; MemtoReg_MEMORYACCESS = 1'b1; RegWrite_MEMORYACCESS = 1'b1;
        ALUResult_MEMORYACCESS = 32'h400; Write_Register_MEMORYACCESS = 5'd9;
        dmem_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3;
        chk("wait_stall", {dmem_req_o, stall_o, ALUResult_WRITEBACK}, {1'b1, 1'b1, 32'h400});
        reset_i = 1'b1;
        zero_inputs();
        #1;
        chk("midwait_reset_port", {dmem_req_o, stall_o}, 64'h0);
        chk("midwait_reset_wb", {ReadData_WRITEBACK, ALUResult_WRITEBACK, Write_Register_WRITEBACK,
                                 MemtoReg_WRITEBACK, RegWrite_WRITEBACK, fault_WRITEBACK}, 64'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        issue(0, 0, 0, 1, 0, 0, 32'h0, 32'h77, 32'h0, 5'd10, 0);                      // back in IDLE
        issue(1, 0, 1, 1, 0, 0, 32'h0, 32'h500, 32'h0, 5'd11, 2);
        @(posedge clk_i);
        #2;
        mon_en = 1'b0;
        chk("queue_drained_end", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
